// File: rtl/ysyx_23060136_fq_pkg.sv
// Shared types and constants for the IFU fetch queue.
// Entry layout, the NOP bubble word and the pointer-width helper live here.
package ysyx_23060136_fq_pkg;

   localparam int FQ_PC_W   = 32;
   localparam int FQ_INST_W = 32;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [FQ_PC_W-1:0]   pc;
      logic [FQ_INST_W-1:0] inst;
   } fq_entry_t;

   // Index bits plus one wrap bit, so full and empty can be told apart.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ysyx_23060136_fq_ptr.sv
// Wrap-bit pointer register for the fetch queue; counts modulo 2*DEPTH.
// Priority: rst > clr > inc.
module ysyx_23060136_fq_ptr
   import ysyx_23060136_fq_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW   = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + PW'(1);
      end
   end

endmodule

// File: rtl/ysyx_23060136_ifu_fetch_queue.sv
// Fetch-to-decode decoupling FIFO of {pc, inst} pairs with one-cycle flush.
// Optional perf counters are enabled by defining YSYX_23060136_FQ_PERF_EN.
module ysyx_23060136_ifu_fetch_queue
   import ysyx_23060136_fq_pkg::*;
#(
   parameter int PC_W   = FQ_PC_W,
   parameter int INST_W = FQ_INST_W,
   parameter int DEPTH  = 4,
   localparam int PW    = ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [PW-1:0]     count
`ifdef YSYX_23060136_FQ_PERF_EN
  ,output logic [31:0]       perf_full_cyc
  ,output logic [31:0]       perf_flush_drop
`endif
);

   localparam int IW = $clog2(DEPTH);

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PC_W-1:0]   mem_pc   [DEPTH];
   logic [INST_W-1:0] mem_inst [DEPTH];
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = wr_ptr - rd_ptr;

   // Flush discards any handshake in the same cycle.
   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   ysyx_23060136_fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (push),
      .ptr (wr_ptr)
   );

   ysyx_23060136_fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (pop),
      .ptr (rd_ptr)
   );

   // NOTE: the entry array has no reset; occupancy comes from the pointers,
   // so stale contents are never observed and plain flops/RAM can be used.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr[IW-1:0]]   <= in_pc;
         mem_inst[wr_ptr[IW-1:0]] <= in_inst;
      end
   end

   // NOTE: outputs get their bubble values first so every path assigns them
   // and no latch is inferred.
   always_comb begin
      out_pc   = '0;
      out_inst = INST_W'(NOP);
      if (!empty) begin
         out_pc   = mem_pc[rd_ptr[IW-1:0]];
         out_inst = mem_inst[rd_ptr[IW-1:0]];
      end
   end

`ifdef YSYX_23060136_FQ_PERF_EN
   logic [32:0] drop_sum;

   assign drop_sum = {1'b0, perf_flush_drop} + 33'(count);

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_full_cyc   <= '0;
         perf_flush_drop <= '0;
      end else begin
         if (full && in_valid) begin
            perf_full_cyc <= perf_full_cyc + 32'd1;
         end
         if (flush) begin
            perf_flush_drop <= drop_sum[32] ? '1 : drop_sum[31:0];
         end
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch_queue.sv
// Self-checking bench: directed vector table, hand sequences for wrap/flush/reset,
// then random traffic against a queue-based reference model.
module tb_ysyx_23060136_ifu_fetch_queue;
   import ysyx_23060136_fq_pkg::*;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [2:0]  count;
`ifdef YSYX_23060136_FQ_PERF_EN
   logic [31:0] perf_full_cyc;
   logic [31:0] perf_flush_drop;
`endif

   int checks = 0;
   int errors = 0;

   ysyx_23060136_ifu_fetch_queue #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .count     (count)
`ifdef YSYX_23060136_FQ_PERF_EN
     ,.perf_full_cyc   (perf_full_cyc)
     ,.perf_flush_drop (perf_flush_drop)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic        in_valid;
      logic        out_ready;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        e_valid;
      logic        e_ready;
      int          e_count;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t vecs[12];

   // Reference model state
   fq_entry_t mq[$];
   longint    m_full_cyc;
   longint    m_drop;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input logic ev, input logic er, input int ec,
                             input logic [31:0] epc, input logic [31:0] einst);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      check({tag, ".in_ready"},  64'(in_ready),  64'(er));
      check({tag, ".count"},     64'(count),     64'(ec));
      check({tag, ".out_pc"},    64'(out_pc),    64'(epc));
      check({tag, ".out_inst"},  64'(out_inst),  64'(einst));
   endtask

   // Apply inputs for one clock, return 1 time unit after the edge.
   task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                        input logic [31:0] p, input logic [31:0] ins);
      rst = r; flush = f; in_valid = iv; out_ready = ordy; in_pc = p; in_inst = ins;
      @(posedge clk);
      #1;
   endtask

   // Random-phase cycle: compare against the model, then advance DUT and model.
   task automatic rcycle(input logic r, input logic f, input logic iv, input logic ordy,
                         input logic [31:0] p, input logic [31:0] ins);
      int        sz;
      fq_entry_t e;
      rst = r; flush = f; in_valid = iv; out_ready = ordy; in_pc = p; in_inst = ins;
      #1;
      sz = mq.size();
      check_outs("rnd", sz != 0, sz < DEPTH, sz,
                 (sz != 0) ? mq[0].pc : 32'h0, (sz != 0) ? mq[0].inst : NOP);
`ifdef YSYX_23060136_FQ_PERF_EN
      check("rnd.perf_full_cyc",   64'(perf_full_cyc),   64'(m_full_cyc[31:0]));
      check("rnd.perf_flush_drop", 64'(perf_flush_drop), 64'(m_drop[31:0]));
`endif
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_full_cyc = 0;
         m_drop     = 0;
      end else begin
         if (sz == DEPTH && iv) m_full_cyc++;
         if (f) begin
            m_drop = m_drop + sz;
            if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
            mq.delete();
         end else begin
            if (sz > 0 && ordy) void'(mq.pop_front());
            if (iv && sz < DEPTH) begin
               e.pc   = p;
               e.inst = ins;
               mq.push_back(e);
            end
         end
      end
      #1;
   endtask

   initial begin
      logic [31:0] spc [10];

      vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          1'b0, 1'b1, 0, 32'h0,          NOP};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0010_0093, 1'b1, 1'b1, 1, 32'h8000_0000, 32'h0010_0093};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0020_0113, 1'b1, 1'b1, 2, 32'h8000_0000, 32'h0010_0093};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0030_0193, 1'b1, 1'b1, 3, 32'h8000_0000, 32'h0010_0093};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h8000_000c, 32'h0040_0213, 1'b1, 1'b0, 4, 32'h8000_0000, 32'h0010_0093};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h0050_0293, 1'b1, 1'b0, 4, 32'h8000_0000, 32'h0010_0093};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'h0050_0293, 1'b1, 1'b1, 3, 32'h8000_0004, 32'h0020_0113};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h0050_0293, 1'b1, 1'b0, 4, 32'h8000_0004, 32'h0020_0113};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,          32'h0,          1'b1, 1'b1, 3, 32'h8000_0008, 32'h0030_0193};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,          32'h0,          1'b1, 1'b1, 2, 32'h8000_000c, 32'h0040_0213};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,          32'h0,          1'b1, 1'b1, 1, 32'h8000_0010, 32'h0050_0293};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0,          32'h0,          1'b0, 1'b1, 0, 32'h0,          NOP};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_inst = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 1'b1, 0, 32'h0, NOP);

      // Reset/idle, single push, fill to full, held-off push, ordered drain
      foreach (vecs[i]) begin
         drive(1'b0, vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready, vecs[i].pc, vecs[i].inst);
         check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_count,
                    vecs[i].e_pc, vecs[i].e_inst);
      end

      // Streaming through pointer wrap: one entry in flight, strict pc order
      for (int k = 0; k < 10; k++) begin
         spc[k] = 32'h9000_0000 + 32'(k * 4);
         drive(1'b0, 1'b0, 1'b1, 1'b1, spc[k], 32'h0000_0013 + 32'(k << 7));
         check($sformatf("stream%0d.count", k), 64'(count), 64'd1);
         check($sformatf("stream%0d.out_pc", k), 64'(out_pc), 64'(spc[k]));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      check("stream_drain.count", 64'(count), 64'd0);

      // Flush with simultaneous push and pop while 3 entries are queued
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0000 + 32'(k * 4), 32'h1111_0000 + 32'(k));
      check("preflush.count", 64'(count), 64'd3);
      rst = 1'b0; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'hA000_00FC; in_inst = 32'h2222_2222;
      #1;
      check("flush.in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      check_outs("postflush", 1'b0, 1'b1, 0, 32'h0, NOP);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
         check($sformatf("flush_idle%0d.out_valid", k), 64'(out_valid), 64'd0);
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hB000_0000, 32'h3333_3333);
      check_outs("after_flush_push", 1'b1, 1'b1, 1, 32'hB000_0000, 32'h3333_3333);

      // Reset asserted mid-stream drops everything
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hB000_0004, 32'h4444_4444);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hB000_0008, 32'h5555_5555);
      check_outs("midreset", 1'b0, 1'b1, 0, 32'h0, NOP);

`ifdef YSYX_23060136_FQ_PERF_EN
      // Five cycles of full & in_valid, then flush four entries
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hC000_0000 + 32'(k * 4), 32'h13);
      check("perf_fill.count", 64'(count), 64'd4);
      for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hC000_0100, 32'h13);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      check("perf.full_cyc",   64'(perf_full_cyc),   64'd5);
      check("perf.flush_drop", 64'(perf_flush_drop), 64'd4);
      check("perf.count",      64'(count),           64'd0);
`endif

      // Random traffic against the reference model
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      mq.delete();
      m_full_cyc = 0;
      m_drop     = 0;
      for (int n = 0; n < 600; n++) begin
         rcycle($urandom_range(99) == 0, $urandom_range(19) == 0, $urandom_range(3) != 0,
                $urandom_range(2) != 0, $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
